// File: rtl/pipe_addsub.sv
// Elastic carry-chained adder/subtractor: one K-bit chunk per stage, operands and partial sums skewed through the pipe.
// Optional output saturation is enabled by defining PIPE_ADDSUB_SAT_EN (adds the sat input).
module pipe_addsub #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         sub,
`ifdef PIPE_ADDSUB_SAT_EN
    input  logic         sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         V
);

    localparam int STAGES = N / K;
    localparam int LAST   = STAGES - 1;

    logic [STAGES-1:0] vld_p;
    logic [STAGES:0]   ld;
    logic              run;

    logic [N-1:0]      a_p [STAGES];
    logic [N-1:0]      b_p [STAGES];
    logic [N-1:0]      s_p [STAGES];
    logic [STAGES-1:0] c_p;
    logic              cm_p;

    logic [N-1:0]      a_in [STAGES];
    logic [N-1:0]      b_in [STAGES];
    logic [N-1:0]      s_in [STAGES];
    logic [N-1:0]      s_nx [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nx;
    logic              cm_nx;
    logic [K+1:0]      r;

    logic              ovf;
    logic [N-1:0]      s_out;

    // Ripple one chunk; returns {carry out, carry into chunk MSB, sum}.
    function automatic logic [K+1:0] add_chunk(input logic [K-1:0] a, input logic [K-1:0] b,
                                               input logic cin);
        logic         c;
        logic         cm;
        logic [K-1:0] s;
        c  = cin;
        cm = 1'b0;
        s  = '0;
        for (int j = 0; j < K; j++) begin
            if (j == K - 1) cm = c;
            s[j] = a[j] ^ b[j] ^ c;
            c    = (a[j] & b[j]) | (c & (a[j] ^ b[j]));
        end
        return {c, cm, s};
    endfunction

`ifdef PIPE_ADDSUB_SAT_EN
    localparam logic signed [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    // A wrapped negative result means the true value overflowed upward.
    function automatic logic signed [N-1:0] saturate(input logic signed [N-1:0] val,
                                                     input logic ov);
        if (!ov) return val;
        return (val < 0) ? MAX_POS : MIN_NEG;
    endfunction

    logic [STAGES-1:0] sat_p;
`endif

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        ld         = '0;
        ld[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ld[i] = !vld_p[i] || ld[i+1];
        end
    end

    assign in_ready = run & ld[0];

    always_comb begin
        a_in[0] = A;
        b_in[0] = sub ? ~B : B;
        c_in[0] = Cin ^ sub;
        s_in[0] = '0;
        for (int i = 1; i < STAGES; i++) begin
            a_in[i] = a_p[i-1];
            b_in[i] = b_p[i-1];
            c_in[i] = c_p[i-1];
            s_in[i] = s_p[i-1];
        end
        cm_nx = 1'b0;
        r     = '0;
        for (int i = 0; i < STAGES; i++) begin
            r                 = add_chunk(a_in[i][i*K +: K], b_in[i][i*K +: K], c_in[i]);
            s_nx[i]           = s_in[i];
            s_nx[i][i*K +: K] = r[K-1:0];
            c_nx[i]           = r[K+1];
            if (i == LAST) cm_nx = r[K];
        end
    end

    // run holds off acceptance until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run   <= 1'b0;
            vld_p <= '0;
        end else begin
            run <= 1'b1;
            if (ld[0]) vld_p[0] <= in_valid & run;
            for (int i = 1; i < STAGES; i++) begin
                if (ld[i]) vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // ---- stage registers p0..p(STAGES-1): chunk i resolved in stage i ----
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (ld[i]) begin
                a_p[i] <= a_in[i];
                b_p[i] <= b_in[i];
                s_p[i] <= s_nx[i];
                c_p[i] <= c_nx[i];
            end
        end
        if (ld[LAST]) cm_p <= cm_nx;
    end

`ifdef PIPE_ADDSUB_SAT_EN
    always_ff @(posedge clk) begin
        if (ld[0]) sat_p[0] <= sat;
        for (int i = 1; i < STAGES; i++) begin
            if (ld[i]) sat_p[i] <= sat_p[i-1];
        end
    end
`endif

    // ---- output: gated to zero while no result is present ----
    assign ovf = c_p[LAST] ^ cm_p;

`ifdef PIPE_ADDSUB_SAT_EN
    assign s_out = sat_p[LAST] ? saturate(s_p[LAST], ovf) : s_p[LAST];
`else
    assign s_out = s_p[LAST];
`endif

    assign out_valid = vld_p[LAST];
    assign S         = out_valid ? s_out : '0;
    assign Cout      = out_valid & c_p[LAST];
    assign V         = out_valid & ovf;

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub (N=16, K=4): directed corners, back-to-back, stall/hold and mid-flight reset.
module tb_pipe_addsub;

    localparam int N  = 16;
    localparam int K  = 4;
    localparam int ST = N / K;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         sub;
    logic         sat_op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] S;
    logic         Cout;
    logic         V;

    pipe_addsub #(.N(N), .K(K)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .sub      (sub),
`ifdef PIPE_ADDSUB_SAT_EN
        .sat      (sat_op),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (S),
        .Cout     (Cout),
        .V        (V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] s;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          n_acc  = 0;
    int          n_out  = 0;
    bit          chk_lat   = 1'b0;
    bit          prev_hold = 1'b0;
    bit          accepted  = 1'b0;
    logic [31:0] held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic ci, input logic su, input logic sa);
        logic [N-1:0] bx;
        logic [N:0]   full;
        exp_t         e;
        bx    = su ? ~b : b;
        full  = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, ci ^ su};
        e.s   = full[N-1:0];
        e.c   = full[N];
        e.v   = (a[N-1] == bx[N-1]) && (e.s[N-1] != a[N-1]);
        e.acc = 0;
`ifdef PIPE_ADDSUB_SAT_EN
        if (sa && e.v) e.s = e.s[N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}};
`else
        if (sa) e.s = e.s;
`endif
        return e;
    endfunction

    // Called at a falling edge with inputs set; samples, scores, advances one clock.
    task automatic tick();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            prev_hold = 1'b0;
            check("no_stale_out", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("S", 32'(S), 32'(e.s));
                check("Cout", 32'(Cout), 32'(e.c));
                check("V", 32'(V), 32'(e.v));
                if (chk_lat) check("latency", cyc - e.acc, ST);
                n_out++;
            end
        end else if (out_valid) begin
            if (prev_hold) check("hold_stable", 32'({S, Cout, V}), held);
            held      = 32'({S, Cout, V});
            prev_hold = 1'b1;
        end else begin
            prev_hold = 1'b0;
            check("idle_zero", 32'({S, Cout, V}), 32'd0);
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            e     = model(A, B, Cin, sub, sat_op);
            e.acc = cyc;
            q.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic offer(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                         input logic su, input logic sa, output int t);
        A = a; B = b; Cin = ci; sub = su; sat_op = sa;
        in_valid = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
        end while (!accepted && t < 20);
        check("accepted", 32'(accepted), 32'd1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() > 0 && g < 50) begin
            tick();
            g++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int a0;
        int o0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Cin = 1'b0; sub = 1'b0; sat_op = 1'b0;

        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_outputs", 32'({S, Cout, V}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);
        @(negedge clk);

        chk_lat = 1'b1;
        offer(16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0, t);
        in_valid = 1'b0;
        drain();

        offer(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, t);
        offer(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, t);
        offer(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, t);
        offer(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, t);
        offer(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, t);
        offer(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, t);
`ifdef PIPE_ADDSUB_SAT_EN
        offer(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, t);
        offer(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, t);
        offer(16'h1000, 16'h0001, 1'b0, 1'b0, 1'b1, t);
`endif
        in_valid = 1'b0;
        drain();

        for (int i = 0; i < 8; i++) begin
            offer(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'b0, t);
            check("b2b_accept_cycles", t, 1);
        end
        in_valid = 1'b0;
        drain();

        chk_lat   = 1'b0;
        out_ready = 1'b0;
        a0 = n_acc;
        o0 = n_out;
        for (int i = 0; i < 8; i++) begin
            A = N'($urandom); B = N'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            tick();
        end
        #1;
        check("stall_accepts", n_acc - a0, 4);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        A = 16'hA5A5; B = 16'h5A5A; Cin = 1'b1; sub = 1'b0;
        #1;
        check("full_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("full_accept", 32'(accepted), 32'd1);
        in_valid = 1'b0;
        drain();
        check("stall_drained", n_out - o0, 5);

        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(N'($urandom), N'($urandom), 1'b0, 1'b0, 1'b0, t);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_outputs", 32'({S, Cout, V}), 32'd0);
        q.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        offer(16'h4321, 16'h1111, 1'b0, 1'b1, 1'b0, t);
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
